// File: rtl/serial_frame_receiver_if.sv
// Bus between a serial frame receiver and its consumer:
// the serial line and acknowledge in, the held word and status flags out.
interface serial_frame_receiver_if #(
    parameter int N = 8
);
    logic         ser_in;
    logic         rd_ack;
    logic [0:N-1] par_out;
    logic         data_valid;
    logic         parity_err;
    logic         frame_err;
    logic         overrun;

    modport master (
        output ser_in,
        output rd_ack,
        input  par_out,
        input  data_valid,
        input  parity_err,
        input  frame_err,
        input  overrun
    );

    modport slave (
        input  ser_in,
        input  rd_ack,
        output par_out,
        output data_valid,
        output parity_err,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/serial_frame_receiver.sv
// Oversampling serial receiver: start, N data bits (first bit ends at par_out[N-1]),
// even parity, stop. Each frame is committed with error flags and a held-word handshake.
module serial_frame_receiver #(
    parameter int N          = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    serial_frame_receiver_if.slave   bus
);
    localparam int HALF  = BIT_CYCLES / 2;
    localparam int CNT_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam int BIT_W = $clog2(N + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [0:N-1] r_shift;
    logic         r_par_acc;
    logic [0:N-1] r_par_out;
    logic         r_data_valid;
    logic         r_parity_err;
    logic         r_frame_err;
    logic         r_overrun;
    logic         w_sample;

    assign w_sample = (r_cnt == CNT_W'(BIT_CYCLES - 1));

    // NOTE: synchronous reset lives inside the clocked block; every register,
    // including the assembly shift register, is cleared so no frame residue survives.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_acc    <= 1'b0;
            r_par_out    <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            // A commit in STOP below overrides this clear on the same edge.
            if (bus.rd_ack && r_data_valid) r_data_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (!bus.ser_in) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end
                START: begin
                    if (r_cnt == CNT_W'(HALF - 1)) begin
                        if (bus.ser_in) begin
                            r_state <= IDLE;
                        end else begin
                            r_state   <= DATA;
                            r_cnt     <= '0;
                            r_bit_cnt <= '0;
                            r_par_acc <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_sample) begin
                        r_cnt     <= '0;
                        r_shift   <= {bus.ser_in, r_shift[0:N-2]};
                        r_par_acc <= r_par_acc ^ bus.ser_in;
                        if (r_bit_cnt == BIT_W'(N - 1)) r_state <= PARITY;
                        else r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (w_sample) begin
                        r_cnt     <= '0;
                        r_par_acc <= r_par_acc ^ bus.ser_in;
                        r_state   <= STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (w_sample) begin
                        r_cnt        <= '0;
                        r_par_out    <= r_shift;
                        r_parity_err <= r_par_acc;
                        r_frame_err  <= ~bus.ser_in;
                        if (r_data_valid && !bus.rd_ack) r_overrun <= 1'b1;
                        r_data_valid <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.par_out    = r_par_out;
    assign bus.data_valid = r_data_valid;
    assign bus.parity_err = r_parity_err;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver (N=8, BIT_CYCLES=4): hand-computed frames,
// commit latency, error flags, glitch rejection, overrun and mid-frame reset.
module tb_serial_frame_receiver;
    localparam int N  = 8;
    localparam int BC = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    serial_frame_receiver_if #(.N(N)) bus ();

    serial_frame_receiver #(.N(N), .BIT_CYCLES(BC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive_bit(input logic b);
        bus.ser_in = b;
        repeat (BC) @(negedge clk);
    endtask

    // Word is sent LSB first, which places word bit k at par_out index N-1-k.
    task automatic send_frame(input logic [7:0] w, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int k = 0; k < N; k++) drive_bit(w[k]);
        drive_bit(par);
        drive_bit(stop);
        bus.ser_in = 1'b1;
    endtask

    task automatic ack_pulse();
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.ser_in = 1'b1; bus.rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset par_out", 32'(bus.par_out), 32'h0);
        chk("reset data_valid", 32'(bus.data_valid), 32'h0);
        chk("reset parity_err", 32'(bus.parity_err), 32'h0);
        chk("reset frame_err", 32'(bus.frame_err), 32'h0);
        chk("reset overrun", 32'(bus.overrun), 32'h0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        fork
            send_frame(8'h4D, 1'b0, 1'b1);
            begin
                repeat (42) @(negedge clk);
                chk("basic dv before commit", 32'(bus.data_valid), 32'h0);
                chk("basic par_out stable", 32'(bus.par_out), 32'h0);
                @(negedge clk);
                chk("basic dv at edge 42", 32'(bus.data_valid), 32'h1);
            end
        join
        chk("basic par_out", 32'(bus.par_out), 32'h4D);
        chk("basic parity_err", 32'(bus.parity_err), 32'h0);
        chk("basic frame_err", 32'(bus.frame_err), 32'h0);
        chk("basic overrun", 32'(bus.overrun), 32'h0);
        ack_pulse();
        chk("basic ack clears dv", 32'(bus.data_valid), 32'h0);
    endtask

    task automatic test_parity_err();
        send_frame(8'h4D, 1'b1, 1'b1);
        chk("parity par_out", 32'(bus.par_out), 32'h4D);
        chk("parity parity_err", 32'(bus.parity_err), 32'h1);
        chk("parity frame_err", 32'(bus.frame_err), 32'h0);
        chk("parity dv", 32'(bus.data_valid), 32'h1);
        ack_pulse();
        ack_pulse();
        chk("idle ack dv", 32'(bus.data_valid), 32'h0);
        chk("idle ack overrun", 32'(bus.overrun), 32'h0);
    endtask

    task automatic test_glitch();
        bus.ser_in = 1'b0;
        @(negedge clk);
        bus.ser_in = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch dv", 32'(bus.data_valid), 32'h0);
        chk("glitch par_out", 32'(bus.par_out), 32'h4D);
        chk("glitch parity_err", 32'(bus.parity_err), 32'h1);
        chk("glitch overrun", 32'(bus.overrun), 32'h0);
    endtask

    task automatic test_frame_err();
        send_frame(8'h96, 1'b0, 1'b0);
        chk("framing par_out", 32'(bus.par_out), 32'h96);
        chk("framing frame_err", 32'(bus.frame_err), 32'h1);
        chk("framing parity_err", 32'(bus.parity_err), 32'h0);
        chk("framing dv", 32'(bus.data_valid), 32'h1);
        ack_pulse();
        repeat (10) @(negedge clk);
        chk("framing recovery dv", 32'(bus.data_valid), 32'h0);
    endtask

    task automatic test_back_to_back();
        send_frame(8'h12, 1'b0, 1'b1);
        send_frame(8'hA7, 1'b1, 1'b1);
        chk("b2b par_out", 32'(bus.par_out), 32'hA7);
        chk("b2b dv", 32'(bus.data_valid), 32'h1);
        chk("b2b overrun", 32'(bus.overrun), 32'h1);
        chk("b2b parity_err", 32'(bus.parity_err), 32'h0);
        ack_pulse();
        chk("b2b ack dv", 32'(bus.data_valid), 32'h0);
        chk("b2b overrun sticky", 32'(bus.overrun), 32'h1);
    endtask

    task automatic test_reset_mid_frame();
        bus.ser_in = 1'b0;
        repeat (10) @(negedge clk);
        bus.ser_in = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst par_out", 32'(bus.par_out), 32'h0);
        chk("midrst dv", 32'(bus.data_valid), 32'h0);
        chk("midrst overrun", 32'(bus.overrun), 32'h0);
        chk("midrst parity_err", 32'(bus.parity_err), 32'h0);
        chk("midrst frame_err", 32'(bus.frame_err), 32'h0);
        repeat (60) @(negedge clk);
        chk("midrst no commit", 32'(bus.data_valid), 32'h0);
        send_frame(8'h3C, 1'b0, 1'b1);
        chk("midrst next par_out", 32'(bus.par_out), 32'h3C);
        chk("midrst next dv", 32'(bus.data_valid), 32'h1);
        chk("midrst next parity_err", 32'(bus.parity_err), 32'h0);
        chk("midrst next frame_err", 32'(bus.frame_err), 32'h0);
    endtask

    initial begin
        reset = 1'b0; bus.ser_in = 1'b1; bus.rd_ack = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity_err();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/serial_frame_receiver.md
SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

Interface
REQ-001 Parameter N SHALL default to 8 and set the data word width in bits.
REQ-002 Parameter BIT_CYCLES SHALL default to 4 and set the clock cycles per serial bit; it SHALL be even and at least 2, and HALF SHALL denote BIT_CYCLES/2.
REQ-003 Clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 ser_in  input  1  serial line, idle high.
REQ-006 rd_ack  input  1  consumer acknowledge of the held word.
REQ-007 Par_out  output  [0:N-1]  last received data word.
REQ-008 data_valid  output  1  Par_out holds an unacknowledged word.
REQ-009 parity_err  output  1  last committed frame failed even parity.
REQ-010 frame_err  output  1  last committed frame had its stop bit sampled 0.
REQ-011 overrun  output  1  sticky flag: a word was lost.

Function
REQ-012 Frame format SHALL be: start bit 0, then N data bits, then an even-parity bit, then stop bit 1.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, with a cycle counter cnt and a bit counter.
REQ-014 IDLE: on an edge with ser_in=0, the FSM SHALL go to START with cnt=0; otherwise it SHALL remain in IDLE.
REQ-015 START: on the edge with cnt=HALF-1, ser_in SHALL be sampled; 1 SHALL cause a return to IDLE (glitch reject, no flags changed), and 0 SHALL cause a move to DATA with cnt=0 and bit count 0.
REQ-016 DATA/PARITY/STOP: cnt SHALL increment every cycle and ser_in SHALL be sampled on the edge with cnt=BIT_CYCLES-1, with cnt cleared to 0 on that edge.
REQ-017 DATA: the k-th sampled data bit (k=0..N-1) SHALL be assigned to Par_out[N-1-k], so the first bit received lands in Par_out[N-1]; after N samples the FSM SHALL move to PARITY.
REQ-018 PARITY: the parity bit SHALL be sampled and the FSM SHALL move to STOP.
REQ-019 STOP, on its sample edge, all of the following SHALL happen:
- Par_out SHALL be loaded with the assembled word.
- parity_err SHALL be set to the XOR of the N data bits and the parity bit.
- frame_err SHALL be set to the inverse of the sampled stop bit.
- data_valid SHALL be set to 1.
- The FSM SHALL go to IDLE.
REQ-020 A frame with a parity or framing error SHALL still be committed per REQ-019.
REQ-021 Par_out SHALL change only on a commit edge or on reset; it SHALL not change while a frame is being assembled.
REQ-022 The commit edge SHALL occur exactly HALF + (N+2)*BIT_CYCLES edges after the IDLE edge that first sees ser_in=0 (42 edges for the default parameters).
REQ-023 rd_ack=1 while data_valid=1 with no commit on the same edge SHALL clear data_valid on that edge.
REQ-024 rd_ack while data_valid=0 SHALL be ignored.
REQ-025 A commit while data_valid=1 and rd_ack=0 SHALL set overrun=1; Par_out, parity_err and frame_err SHALL be overwritten, and data_valid SHALL stay 1.
REQ-026 A commit with rd_ack=1 on the same edge SHALL leave data_valid=1 and SHALL not set overrun.
REQ-027 overrun SHALL be cleared only by reset.
REQ-028 IDLE SHALL be re-entered directly after STOP, so back-to-back frames with no idle bits SHALL be received.

Reset
REQ-029 On an edge with reset=0, the following SHALL apply:
- The FSM SHALL go to IDLE, and cnt and the bit count SHALL be 0.
- Par_out SHALL be all zeros.
- data_valid, parity_err, frame_err and overrun SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame, and the frame SHALL not be committed.
REQ-031 After reset is released, reception SHALL restart only on a new ser_in=0 seen in IDLE.

Verification (N=8, BIT_CYCLES=4)
REQ-032 The bench SHALL send data bits 1,0,1,1,0,0,1,0, parity 0, stop 1 -> Par_out=8'h4D, data_valid=1 exactly 42 edges after start detection, parity_err=0, frame_err=0.
REQ-033 The bench SHALL send the same frame with parity bit 1 -> Par_out=8'h4D, parity_err=1, data_valid=1.
REQ-034 The bench SHALL drive ser_in low for 1 cycle only, then high -> the FSM returns to IDLE and data_valid stays 0 with no flag change.
REQ-035 The bench SHALL send two back-to-back frames with no rd_ack -> Par_out holds the second word, data_valid=1, overrun=1; a subsequent rd_ack clears data_valid, and overrun remains 1.
REQ-036 The bench SHALL assert reset=0 for one edge during the DATA state -> all outputs are 0 and the FSM is in IDLE; a following valid frame is received correctly.
REQ-037 The bench SHALL send a frame with stop bit 0 -> frame_err=1, and the word is committed.
